mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width in bits.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for multiply ops (legal range 1 or more).
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for divide ops (legal range 1 or more).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port start  input  1  meaning the op is valid this cycle.
REQ-007 The block SHALL have port operation  input  4  meaning the op code (MDU_* constant).
REQ-008 The block SHALL have port operand1  input  WIDTH  meaning rs value; dividend, or source for MTHI/MTLO.
REQ-009 The block SHALL have port operand2  input  WIDTH  meaning rt value; divisor.
REQ-010 The block SHALL have port busy  output  1  meaning a multi-cycle op is in progress.
REQ-011 The block SHALL have port hi  output  WIDTH  meaning the architectural HI register (MFHI source).
REQ-012 The block SHALL have port lo  output  WIDTH  meaning the architectural LO register (MFLO source).

Function
REQ-013 The block SHALL implement two states: IDLE (busy=0) and BUSY (busy=1).
REQ-014 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch the full result into pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the next edge.
REQ-015 busy SHALL be high for exactly N consecutive cycles after the start cycle, where N is the loaded latency.
REQ-016 hi/lo SHALL update from the pending registers at the edge ending the last busy cycle, the same edge busy falls.
REQ-017 During BUSY, hi/lo SHALL hold their pre-op values.
REQ-018 MULT SHALL produce the signed 2*WIDTH product and MULTU the unsigned one, with hi taking the upper WIDTH bits and lo the lower WIDTH bits.
REQ-019 DIV/DIVU SHALL give lo the quotient and hi the remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Signed most-negative divided by -1 SHALL give lo = most-negative value and hi = 0.
REQ-021 Divisor 0 SHALL run the full DIV_CYCLES with busy high and then leave hi/lo unchanged.
REQ-022 In IDLE, start with MTHI/MTLO SHALL write operand1 into hi/lo at the next edge with busy staying 0 (single cycle).
REQ-023 start while BUSY, of any op, SHALL be ignored (the controller stalls), with no change to the pending result or the counter.
REQ-024 start with MDU_NONE or any unassigned code SHALL be ignored.
REQ-025 Back-to-back ops SHALL be legal: a start in the first cycle after busy falls SHALL be accepted.

Reset
REQ-026 While reset is high at an edge, hi, lo, the pending registers and the counter SHALL clear to 0, the state SHALL become IDLE, and busy SHALL be 0.
REQ-027 Reset during BUSY SHALL abandon the op, with no hi/lo commit.
REQ-028 Reset SHALL take priority over a simultaneous start.

Structure
REQ-029 The op codes MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6 SHALL live in the shared macros file as `define constants, alongside the existing ALU/CMP codes.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 Product and quotient SHALL be computed combinationally at start; the latency is modelled by the counter only.

Verification
REQ-032 WIDTH=32: MULT -3 x 5 -> busy high cycles 1-5; after that, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-033 MULTU FFFFFFFF x 2 -> hi=00000001, lo=FFFFFFFE.
REQ-034 DIVU 7/2 -> lo=3, hi=1 after 10 busy cycles; DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-035 MTHI 1234 then DIV x/0 -> busy high for 10 cycles, then hi=1234 and lo unchanged.
REQ-036 MULT started, then MTLO 55 while busy -> MTLO ignored; lo = product at busy fall.
REQ-037 DIV started, then reset in busy cycle 4 -> busy=0 and hi=lo=0 next cycle; a new MULT is accepted the following cycle.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared op-code macros and the package view of them used by the multiply/divide unit.
// The `define constants serve non-package users; the package mirrors them as typed localparams.
`ifndef MUL_DIV_UNIT_MACROS
`define MUL_DIV_UNIT_MACROS
`define MDU_NONE  4'd0
`define MDU_MULT  4'd1
`define MDU_MULTU 4'd2
`define MDU_DIV   4'd3
`define MDU_DIVU  4'd4
`define MDU_MTHI  4'd5
`define MDU_MTLO  4'd6
`endif

package mul_div_unit_pkg;
  localparam logic [3:0] OP_NONE  = `MDU_NONE;
  localparam logic [3:0] OP_MULT  = `MDU_MULT;
  localparam logic [3:0] OP_MULTU = `MDU_MULTU;
  localparam logic [3:0] OP_DIV   = `MDU_DIV;
  localparam logic [3:0] OP_DIVU  = `MDU_DIVU;
  localparam logic [3:0] OP_MTHI  = `MDU_MTHI;
  localparam logic [3:0] OP_MTLO  = `MDU_MTLO;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
endpackage

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: result computed at start, latency modelled by a down-counter.
// state   | meaning
// ST_IDLE | accepts MULT/MULTU/DIV/DIVU (-> BUSY) and single-cycle MTHI/MTLO
// ST_BUSY | counting down the op latency; hi/lo hold, new starts are ignored
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_wr;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, dsr_s, dsr_u;
  logic [WIDTH-1:0]   q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_wr, is_long;
  logic [CNT_W-1:0]   res_cycles;

  always_comb begin
    prod_s   = {{WIDTH{operand1[WIDTH-1]}}, operand1} * {{WIDTH{operand2[WIDTH-1]}}, operand2};
    prod_u   = {{WIDTH{1'b0}}, operand1} * {{WIDTH{1'b0}}, operand2};
    a_neg    = operand1[WIDTH-1];
    b_neg    = operand2[WIDTH-1];
    div_zero = (operand2 == '0);
    abs_a    = a_neg ? -operand1 : operand1;
    abs_b    = b_neg ? -operand2 : operand2;
    // Substitute a divisor of 1 when dividing by zero; the result is discarded anyway.
    dsr_s    = div_zero ? ONE : abs_b;
    dsr_u    = div_zero ? ONE : operand2;
    q_mag    = abs_a / dsr_s;
    r_mag    = abs_a % dsr_s;
    quot_s   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem_s    = a_neg ? -r_mag : r_mag;
    quot_u   = operand1 / dsr_u;
    rem_u    = operand1 % dsr_u;
  end

  always_comb begin
    res_hi     = '0;
    res_lo     = '0;
    res_wr     = 1'b0;
    is_long    = 1'b0;
    res_cycles = '0;
    case (operation)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_wr = 1'b1; is_long = 1'b1; res_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_wr = 1'b1; is_long = 1'b1; res_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        res_hi = rem_s; res_lo = quot_s;
        res_wr = !div_zero; is_long = 1'b1; res_cycles = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res_hi = rem_u; res_lo = quot_u;
        res_wr = !div_zero; is_long = 1'b1; res_cycles = CNT_W'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && is_long) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            count   <= res_cycles;
            state   <= ST_BUSY;
          end else if (start && operation == OP_MTHI) begin
            hi <= operand1;
          end else if (start && operation == OP_MTLO) begin
            lo <= operand1;
          end
        end
        default: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_IDLE;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_BUSY);
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, busy lengths, stall and reset cases.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  operation = OP_NONE;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy;

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand1(operand1), .operand2(operand2), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operation = op; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0; operation = OP_NONE;
  endtask

  // Counts busy cycles from the current one until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy_rise", {31'd0, busy}, 32'd1);
    chk("mult_hold_hi", hi, 32'h0);
    chk("mult_hold_lo", lo, 32'h0);
    wait_idle(n_busy);
    chk("mult_cycles", n_busy, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // Back-to-back: started in the first cycle after busy fell.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_busy_rise", {31'd0, busy}, 32'd1);
    wait_idle(n_busy);
    chk("multu_cycles", n_busy, 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle(n_busy);
    chk("divu_cycles", n_busy, 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n_busy);
    chk("div_cycles", n_busy, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'd99, 32'd0);
    wait_idle(n_busy);
    chk("div0_cycles", n_busy, 32'd10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n_busy);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // MTLO while busy must be ignored.
    issue(OP_MULT, 32'd3, 32'd4);
    issue(OP_MTLO, 32'h55, 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_lo_hold", lo, 32'h8000_0000);
    wait_idle(n_busy);
    chk("stall_cycles_left", n_busy, 32'd4);
    chk("stall_lo", lo, 32'h0000_000C);
    chk("stall_hi", hi, 32'h0);

    issue(OP_MTLO, 32'h55, 32'd0);
    chk("mtlo_lo", lo, 32'h55);
    issue(OP_NONE, 32'hDEAD_BEEF, 32'd1);
    chk("none_busy", {31'd0, busy}, 32'd0);
    chk("none_lo", lo, 32'h55);
    issue(4'd9, 32'hDEAD_BEEF, 32'd1);
    chk("badop_busy", {31'd0, busy}, 32'd0);
    chk("badop_hi", hi, 32'h0);

    // Reset during busy cycle 4 of a divide, then a MULT the following cycle.
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstbusy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstbusy_busy", {31'd0, busy}, 32'd0);
    chk("rstbusy_hi", hi, 32'h0);
    chk("rstbusy_lo", lo, 32'h0);
    issue(OP_MULT, 32'd6, 32'd7);
    chk("postrst_busy", {31'd0, busy}, 32'd1);
    wait_idle(n_busy);
    chk("postrst_cycles", n_busy, 32'd5);
    chk("postrst_lo", lo, 32'd42);
    chk("postrst_hi", hi, 32'h0);

    // Reset wins over a simultaneous start.
    issue(OP_MTHI, 32'h77, 32'd0);
    reset = 1'b1;
    issue(OP_MULT, 32'd2, 32'd3);
    reset = 1'b0;
    chk("rstprio_busy", {31'd0, busy}, 32'd0);
    chk("rstprio_hi", hi, 32'h0);
    chk("rstprio_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
